w_ser_fifo: RTL and testbench

N-channel weight buffer that accepts full-width signed INT weights in parallel and emits them bit-serially, one bit per `rd_en`, into the columns of the FP-INT systolic array. It sits between the weight loader and the `w_in` column inputs of `mm`. It replaces the current 1-bit weight FIFO, whose feeder has to pre-serialise every weight. Precision (1..W_MAX bits) and bit order are selected at run time, and each column drains independently so it can follow the array's `active_column` skew.

---
 rtl/w_ser_pkg.sv | 13 +
 rtl/w_ser_fifo_if.sv | 29 ++
 rtl/w_ser_lane.sv | 100 ++++++++++
 rtl/w_ser_fifo.sv | 70 +++++++
 tb/tb_w_ser_fifo.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/w_ser_pkg.sv
// Shared defaults and width helper for the bit-serial weight buffer.
package w_ser_pkg;

    localparam int W_MAX_DEF = 8;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/w_ser_fifo_if.sv
// Loader/array-facing bundle of the bit-serial weight buffer.
// Master drives writes, reads and mode; slave returns data and flags.
interface w_ser_fifo_if
    import w_ser_pkg::*;
#(
    parameter int N     = 2,
    parameter int W_MAX = W_MAX_DEF
);
    logic [3:0]         precision;
    logic               msb_first;
    logic [N-1:0]       wr_valid;
    logic [N*W_MAX-1:0] wr_data;
    logic [N-1:0]       wr_ready;
    logic [N-1:0]       rd_en;
    logic [N-1:0]       dout;
    logic [N-1:0]       empty;
    logic [N-1:0]       full;
    logic [N-1:0]       underflow;

    modport master (
        output precision, msb_first, wr_valid, wr_data, rd_en,
        input  wr_ready, dout, empty, full, underflow
    );

    modport slave (
        input  precision, msb_first, wr_valid, wr_data, rd_en,
        output wr_ready, dout, empty, full, underflow
    );
endinterface

// File: rtl/w_ser_lane.sv
// One channel: word FIFO feeding a shift stage that emits one bit per rd_en.
// Write-to-first-bit 2 cycles, no bubble between words; writes refused while full.
module w_ser_lane
    import w_ser_pkg::*;
#(
    parameter int W_MAX = W_MAX_DEF,
    parameter int DEPTH = 16
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       prec,
    input  logic             msb,
    input  logic             wr_valid,
    input  logic [W_MAX-1:0] wr_data,
    output logic             wr_ready,
    input  logic             rd_en,
    output logic             dout,
    output logic             empty,
    output logic             full,
    output logic             underflow,
    output logic             idle
);
    localparam int AW = clog2(DEPTH);
    localparam int BW = (W_MAX > 1) ? clog2(W_MAX) : 1;

    logic [W_MAX-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic [W_MAX-1:0] word_q, word_d;
    logic             vld_q, vld_d;
    logic [BW-1:0]    bcnt_q, bcnt_d;
    logic             udf_q, udf_d;
    logic             push, pop, adv, last;
    logic [BW-1:0]    idx;

    assign full      = (cnt_q == (AW+1)'(DEPTH));
    assign wr_ready  = !full;
    assign empty     = !vld_q;
    assign underflow = udf_q;
    assign idle      = !vld_q && (cnt_q == '0);
    assign dout      = vld_q && word_q[idx];

    always_comb begin
        push   = wr_valid && !full;
        adv    = rd_en && vld_q;
        last   = (32'(bcnt_q) + 32'd1) == 32'(prec);
        // Reload on the last bit keeps back-to-back words bubble-free.
        pop    = (!vld_q || (adv && last)) && (cnt_q != '0);
        wptr_d = push ? wptr_q + 1'b1 : wptr_q;
        rptr_d = pop ? rptr_q + 1'b1 : rptr_q;
        cnt_d  = cnt_q;
        if (push && !pop)
            cnt_d = cnt_q + 1'b1;
        else if (!push && pop)
            cnt_d = cnt_q - 1'b1;
        word_d = word_q;
        vld_d  = vld_q;
        bcnt_d = bcnt_q;
        if (pop) begin
            word_d = mem_q[rptr_q];
            vld_d  = 1'b1;
            bcnt_d = '0;
        end else if (adv && last) begin
            vld_d  = 1'b0;
            bcnt_d = '0;
        end else if (adv) begin
            bcnt_d = bcnt_q + 1'b1;
        end
        udf_d = udf_q || (rd_en && !vld_q);
        idx   = msb ? BW'(32'(prec) - 32'd1 - 32'(bcnt_q)) : bcnt_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            word_q <= '0;
            vld_q  <= 1'b0;
            bcnt_q <= '0;
            udf_q  <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            word_q <= word_d;
            vld_q  <= vld_d;
            bcnt_q <= bcnt_d;
            udf_q  <= udf_d;
        end
    end

    // Storage needs no reset: the count and stage-valid flag gate every read.
    always_ff @(posedge clk) begin
        if (push)
            mem_q[wptr_q] <= wr_data;
    end

endmodule

// File: rtl/w_ser_fifo.sv
// N-channel buffer turning parallel INT weights into per-column bit streams.
// First bit 2 cycles after write; per-channel wr_ready drops while that FIFO is full.
module w_ser_fifo
    import w_ser_pkg::*;
#(
    parameter int N     = 2,
    parameter int W_MAX = W_MAX_DEF,
    parameter int DEPTH = 16
)
(
    input  logic         clk,
    input  logic         rst,
    w_ser_fifo_if.slave  bus
);
    logic [3:0]   prec_q, prec_d, prec_clamp;
    logic         msb_q, msb_d;
    logic [N-1:0] lane_idle;
    logic         all_idle;
    logic [N-1:0] lane_wr_ready, lane_dout, lane_empty, lane_full, lane_udf;

    assign bus.wr_ready  = lane_wr_ready;
    assign bus.dout      = lane_dout;
    assign bus.empty     = lane_empty;
    assign bus.full      = lane_full;
    assign bus.underflow = lane_udf;

    // Mode only follows the inputs while every lane is drained.
    always_comb begin
        prec_clamp = bus.precision;
        if (bus.precision == 4'd0)
            prec_clamp = 4'd1;
        else if (32'(bus.precision) > W_MAX)
            prec_clamp = 4'(W_MAX);
        all_idle = &lane_idle;
        prec_d   = all_idle ? prec_clamp : prec_q;
        msb_d    = all_idle ? bus.msb_first : msb_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prec_q <= 4'd1;
            msb_q  <= 1'b0;
        end else begin
            prec_q <= prec_d;
            msb_q  <= msb_d;
        end
    end

    for (genvar c = 0; c < N; c++) begin : g_lane
        w_ser_lane #(
            .W_MAX (W_MAX),
            .DEPTH (DEPTH)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .prec      (prec_q),
            .msb       (msb_q),
            .wr_valid  (bus.wr_valid[c]),
            .wr_data   (bus.wr_data[c*W_MAX +: W_MAX]),
            .wr_ready  (lane_wr_ready[c]),
            .rd_en     (bus.rd_en[c]),
            .dout      (lane_dout[c]),
            .empty     (lane_empty[c]),
            .full      (lane_full[c]),
            .underflow (lane_udf[c]),
            .idle      (lane_idle[c])
        );
    end

endmodule

// File: tb/tb_w_ser_fifo.sv
// Directed bench for w_ser_fifo: queue-based reference model checked every cycle
// plus hand-computed bit sequences for each scenario.
module tb_w_ser_fifo;

    localparam int N     = 2;
    localparam int WM    = 8;
    localparam int DEPTH = 4;

    logic clk;
    logic rst;

    w_ser_fifo_if #(.N(N), .W_MAX(WM)) bus ();

    w_ser_fifo #(.N(N), .W_MAX(WM), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: words waiting per channel, and the remaining bits of the word
    // currently being shifted, already expanded in emission order.
    logic [WM-1:0] mfifo  [N][$];
    bit            mstage [N][$];
    bit            mudf   [N];
    int            mprec = 1;
    bit            mmsb  = 1'b0;

    always @(posedge clk or negedge rst) begin : model
        bit            idle_now;
        bit            can_push;
        logic [WM-1:0] w;
        if (!rst) begin
            for (int c = 0; c < N; c++) begin
                mfifo[c].delete();
                mstage[c].delete();
                mudf[c] = 1'b0;
            end
            mprec = 1;
            mmsb  = 1'b0;
        end else begin
            idle_now = 1'b1;
            for (int c = 0; c < N; c++)
                if (mfifo[c].size() != 0 || mstage[c].size() != 0) idle_now = 1'b0;
            for (int c = 0; c < N; c++) begin
                can_push = mfifo[c].size() < DEPTH;
                if (bus.rd_en[c]) begin
                    if (mstage[c].size() == 0) mudf[c] = 1'b1;
                    else void'(mstage[c].pop_front());
                end
                if (mstage[c].size() == 0 && mfifo[c].size() != 0) begin
                    w = mfifo[c].pop_front();
                    for (int i = 0; i < mprec; i++)
                        mstage[c].push_back(mmsb ? w[mprec-1-i] : w[i]);
                end
                if (bus.wr_valid[c] && can_push)
                    mfifo[c].push_back(bus.wr_data[c*WM +: WM]);
            end
            if (idle_now) begin
                mprec = (bus.precision == 0) ? 1 : ((bus.precision > WM) ? WM : int'(bus.precision));
                mmsb  = bus.msb_first;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Outputs: {dout, empty, full, wr_ready, underflow} per channel.
    logic [4:0] cmp_act, cmp_exp;
    always @(negedge clk) begin
        for (int c = 0; c < N; c++) begin
            cmp_act = {bus.dout[c], bus.empty[c], bus.full[c], bus.wr_ready[c], bus.underflow[c]};
            cmp_exp = {(mstage[c].size() != 0) ? mstage[c][0] : 1'b0,
                       mstage[c].size() == 0,
                       mfifo[c].size() == DEPTH,
                       mfifo[c].size() != DEPTH,
                       mudf[c]};
            chk($sformatf("model ch%0d {dout,empty,full,rdy,udf}", c), 32'(cmp_act), 32'(cmp_exp));
        end
    end

    task automatic cyc(input logic [N-1:0] wv, input logic [N*WM-1:0] wd, input logic [N-1:0] re);
        bus.wr_valid = wv;
        bus.wr_data  = wd;
        bus.rd_en    = re;
        @(posedge clk);
        #1;
        bus.wr_valid = '0;
        bus.rd_en    = '0;
    endtask

    // bits[i] is the i-th bit expected out of channel ch.
    task automatic rd_bits(input string nm, input int ch, input int n, input logic [31:0] bits);
        logic [N-1:0] re;
        re = '0;
        re[ch] = 1'b1;
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s bit%0d", nm, i), 32'(bus.dout[ch]), 32'(bits[i]));
            chk($sformatf("%s empty bit%0d", nm, i), 32'(bus.empty[ch]), 32'd0);
            cyc('0, '0, re);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst           = 1'b0;
        bus.precision = 4'd4;
        bus.msb_first = 1'b0;
        bus.wr_valid  = '0;
        bus.wr_data   = '0;
        bus.rd_en     = '0;
        @(posedge clk); @(posedge clk); #1;
        chk("reset empty", 32'(bus.empty), 32'h3);
        chk("reset full", 32'(bus.full), 32'h0);
        chk("reset wr_ready", 32'(bus.wr_ready), 32'h3);
        chk("reset dout", 32'(bus.dout), 32'h0);
        chk("reset underflow", 32'(bus.underflow), 32'h0);
        rst = 1'b1;
        cyc('0, '0, '0);

        // LSB-first, 0xA at precision 4
        cyc(2'b01, 16'h000A, '0);
        chk("lsb empty before load", 32'(bus.empty[0]), 32'd1);
        cyc('0, '0, '0);
        rd_bits("lsb", 0, 4, 32'hA);
        chk("lsb empty after", 32'(bus.empty[0]), 32'd1);

        // MSB-first, 0xA at precision 4 then 0x5 at precision 3
        bus.msb_first = 1'b1;
        cyc(2'b01, 16'h000A, '0);
        cyc('0, '0, '0);
        rd_bits("msb4", 0, 4, 32'h5);
        bus.precision = 4'd3;
        cyc(2'b01, 16'h0005, '0);
        cyc('0, '0, '0);
        rd_bits("msb3", 0, 3, 32'h5);
        chk("msb3 empty after", 32'(bus.empty[0]), 32'd1);

        // Back-to-back words 0x3, 0xC
        bus.msb_first = 1'b0;
        bus.precision = 4'd4;
        cyc(2'b01, 16'h0003, '0);
        cyc(2'b01, 16'h000C, '0);
        rd_bits("b2b", 0, 8, 32'hC3);
        chk("b2b empty after", 32'(bus.empty[0]), 32'd1);

        // Fill ch1: words 1..5 accepted, 6 dropped
        for (int k = 1; k <= 5; k++) cyc(2'b10, 16'(k << 8), '0);
        chk("full flag", 32'(bus.full[1]), 32'd1);
        chk("full wr_ready", 32'(bus.wr_ready[1]), 32'd0);
        cyc(2'b10, 16'h0600, '0);
        chk("full after drop", 32'(bus.full[1]), 32'd1);
        rd_bits("drain", 1, 20, 32'h54321);
        chk("drain empty after", 32'(bus.empty[1]), 32'd1);
        cyc('0, '0, '0);
        chk("dropped word absent", 32'(bus.empty[1]), 32'd1);

        // Precision change mid-word is ignored until idle
        cyc(2'b01, 16'h0009, '0);
        cyc('0, '0, '0);
        rd_bits("mid0", 0, 1, 32'h1);
        bus.precision = 4'd2;
        rd_bits("mid1", 0, 3, 32'h4);
        chk("mid empty after", 32'(bus.empty[0]), 32'd1);
        cyc(2'b01, 16'h0006, '0);
        cyc('0, '0, '0);
        rd_bits("prec2", 0, 2, 32'h2);
        chk("prec2 empty after", 32'(bus.empty[0]), 32'd1);

        // Clamping: 0 -> 1 bit, 15 -> W_MAX bits
        bus.precision = 4'd0;
        cyc(2'b01, 16'h0003, '0);
        cyc('0, '0, '0);
        rd_bits("clamp0", 0, 1, 32'h1);
        chk("clamp0 empty after", 32'(bus.empty[0]), 32'd1);
        bus.precision = 4'd15;
        bus.msb_first = 1'b1;
        cyc(2'b01, 16'h0080, '0);
        cyc('0, '0, '0);
        rd_bits("clamp15", 0, 8, 32'h01);
        chk("clamp15 empty after", 32'(bus.empty[0]), 32'd1);

        // Underflow is sticky and changes nothing else
        cyc('0, '0, 2'b01);
        chk("udf set", 32'(bus.underflow), 32'h1);
        chk("udf dout", 32'(bus.dout), 32'h0);
        chk("udf empty", 32'(bus.empty), 32'h3);
        cyc('0, '0, '0);
        chk("udf sticky", 32'(bus.underflow), 32'h1);

        // Reset mid-stream discards everything
        bus.msb_first = 1'b0;
        bus.precision = 4'd4;
        cyc(2'b11, 16'hFFFF, '0);
        cyc(2'b11, 16'hFFFF, '0);
        cyc('0, '0, '0);
        rd_bits("pre-rst", 0, 1, 32'h1);
        #2;
        rst = 1'b0;
        #1;
        chk("async rst empty", 32'(bus.empty), 32'h3);
        chk("async rst dout", 32'(bus.dout), 32'h0);
        chk("async rst udf", 32'(bus.underflow), 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        cyc('0, '0, '0);
        cyc('0, '0, '0);
        chk("post rst empty", 32'(bus.empty), 32'h3);
        chk("post rst dout", 32'(bus.dout), 32'h0);
        cyc(2'b01, 16'h0005, '0);
        cyc('0, '0, '0);
        rd_bits("post rst word", 0, 4, 32'h5);
        chk("post rst empty after", 32'(bus.empty), 32'h3);

        cyc('0, '0, '0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
